// File: rtl/sram_nr1w.sv
// sram_nr1w: DEPTH x DATA_W storage with one write port and NUM_RD registered
// read ports. Reads have one-cycle latency and see a same-cycle write to the
// same address (write-first). Out-of-range accesses are dropped on write and
// return zero on read, with a one-cycle AddrError pulse. A Clear request
// starts a sweep that zeroes one word per cycle while Busy is high.
// Optional feature macro: SRAM_PARITY_EN adds an even-parity bit per entry
// and drives ParityError; without it ParityError is tied low.
module sram_nr1w #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024,
    parameter int NUM_RD = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       WE,
    input  logic [ADDR_W-1:0]          WriteAddress,
    input  logic [DATA_W-1:0]          WriteBus,
    input  logic                       InjectParity,
    input  logic [NUM_RD-1:0]          ReadEnable,
    input  logic [NUM_RD*ADDR_W-1:0]   ReadAddress,
    output logic [NUM_RD*DATA_W-1:0]   ReadBus,
    output logic [NUM_RD-1:0]          ReadValid,
    output logic [NUM_RD-1:0]          ParityError,
    output logic                       AddrError,
    input  logic                       Clear,
    output logic                       Busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // DEPTH in one extra bit so DEPTH == 2**ADDR_W still compares correctly
    localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

`ifdef SRAM_PARITY_EN
    localparam int ENTRY_W = DATA_W + 1;
`else
    localparam int ENTRY_W = DATA_W;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic               addr_err_q, addr_err_d;

    logic [ENTRY_W-1:0] Register [0:DEPTH-1];

    logic               wr_in_range;
    logic               wr_fire;
    logic [IDX_W-1:0]   wr_idx;
    logic [ENTRY_W-1:0] wr_entry;
    logic [NUM_RD-1:0]  rd_oor;

    assign wr_in_range = ({1'b0, WriteAddress} < DEPTH_X);
    assign wr_idx      = WriteAddress[IDX_W-1:0];
    assign wr_fire     = (state_q == IDLE) && WE && wr_in_range;

`ifdef SRAM_PARITY_EN
    // Stored parity makes the whole entry even; InjectParity flips it for tests
    assign wr_entry = {(^WriteBus) ^ InjectParity, WriteBus};
`else
    logic unused_inject;
    assign unused_inject = InjectParity;
    assign wr_entry      = WriteBus;
`endif

    // Next-state logic for the clear sweep and the address-error pulse
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        addr_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                addr_err_d = (|rd_oor) || (WE && !wr_in_range);
                if (Clear) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                // Clear requests here are ignored; the sweep just runs out
                if (clr_cnt_q == LAST_IDX) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Control registers; reset aborts a sweep mid-way
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            clr_cnt_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Array write: sweep zeros (parity 0) while clearing, else the user write
    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (state_q == CLEAR) begin
                Register[clr_cnt_q] <= '0;
            end else if (wr_fire) begin
                Register[wr_idx] <= wr_entry;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0]  addr;
            logic               in_range;
            logic [ENTRY_W-1:0] entry;
            logic [DATA_W-1:0]  data_d, data_q;
            logic               valid_d, valid_q;
            logic               perr_d, perr_q;

            assign addr       = ReadAddress[gi*ADDR_W +: ADDR_W];
            assign in_range   = ({1'b0, addr} < DEPTH_X);
            assign rd_oor[gi] = (state_q == IDLE) && ReadEnable[gi] && !in_range;

            // Per-port read with write-first forwarding; data holds when idle
            always_comb begin
                data_d  = data_q;
                valid_d = 1'b0;
                perr_d  = 1'b0;
                entry   = '0;
                if ((state_q == IDLE) && ReadEnable[gi]) begin
                    valid_d = 1'b1;
                    if (!in_range) begin
                        data_d = '0;
                    end else begin
                        if (wr_fire && (WriteAddress == addr)) begin
                            entry = wr_entry;
                        end else begin
                            entry = Register[addr[IDX_W-1:0]];
                        end
                        data_d = entry[DATA_W-1:0];
`ifdef SRAM_PARITY_EN
                        perr_d = ^entry;
`endif
                    end
                end
            end

            // Read output registers
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                    perr_q  <= 1'b0;
                end else begin
                    data_q  <= data_d;
                    valid_q <= valid_d;
                    perr_q  <= perr_d;
                end
            end

            assign ReadBus[gi*DATA_W +: DATA_W] = data_q;
            assign ReadValid[gi]                = valid_q;
`ifdef SRAM_PARITY_EN
            assign ParityError[gi]              = perr_q;
`else
            assign ParityError[gi]              = 1'b0;
`endif
        end
    endgenerate

    assign AddrError = addr_err_q;
    assign Busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_sram_nr1w.sv
// Bench for sram_nr1w (default parameters, DEPTH=1024, two read ports).
// Expected read results are queued per port when a read is driven and
// popped when ReadValid appears. Honours SRAM_PARITY_EN if defined.
module tb_sram_nr1w;
    localparam int DATA_W = 128;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 1024;
    localparam int NUM_RD = 2;

    logic                     clock;
    logic                     reset_n;
    logic                     WE;
    logic [ADDR_W-1:0]        WriteAddress;
    logic [DATA_W-1:0]        WriteBus;
    logic                     InjectParity;
    logic [NUM_RD-1:0]        ReadEnable;
    logic [NUM_RD*ADDR_W-1:0] ReadAddress;
    logic [NUM_RD*DATA_W-1:0] ReadBus;
    logic [NUM_RD-1:0]        ReadValid;
    logic [NUM_RD-1:0]        ParityError;
    logic                     AddrError;
    logic                     Clear;
    logic                     Busy;

    sram_nr1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .WE           (WE),
        .WriteAddress (WriteAddress),
        .WriteBus     (WriteBus),
        .InjectParity (InjectParity),
        .ReadEnable   (ReadEnable),
        .ReadAddress  (ReadAddress),
        .ReadBus      (ReadBus),
        .ReadValid    (ReadValid),
        .ParityError  (ParityError),
        .AddrError    (AddrError),
        .Clear        (Clear),
        .Busy         (Busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int                stamp;
        logic [DATA_W-1:0] data;
        logic              perr;
    } exp_t;

    exp_t              sb [NUM_RD][$];
    logic [DATA_W-1:0] model [DEPTH];
    logic              bad   [DEPTH];
    logic [DATA_W-1:0] last_data [NUM_RD];
    int                clr_left;
    int                clr_ptr;
    int                cyc;
    int                n_chk;
    int                n_pass;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    endtask

    // One clock cycle: drive inputs, update the model, then check outputs
    task automatic drive_cycle(input logic rst, input logic we,
                               input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd, input logic inj,
                               input logic [NUM_RD-1:0] ren,
                               input logic [NUM_RD*ADDR_W-1:0] ra,
                               input logic clr);
        logic exp_aerr;
        logic exp_v;
        exp_t e;
        int   a;
        @(negedge clock);
        reset_n      = ~rst;
        WE           = we;
        WriteAddress = wa;
        WriteBus     = wd;
        InjectParity = inj;
        ReadEnable   = ren;
        ReadAddress  = ra;
        Clear        = clr;
        cyc++;
        exp_aerr = 1'b0;
        if (rst) begin
            clr_left = 0;
            for (int p = 0; p < NUM_RD; p++) last_data[p] = '0;
        end else if (clr_left > 0) begin
            model[clr_ptr] = '0;
            bad[clr_ptr]   = 1'b0;
            clr_ptr++;
            clr_left--;
        end else begin
            if (we) begin
                if (int'(wa) < DEPTH) begin
                    model[wa] = wd;
`ifdef SRAM_PARITY_EN
                    bad[wa] = inj;
`else
                    bad[wa] = 1'b0;
`endif
                end else begin
                    exp_aerr = 1'b1;
                end
            end
            for (int p = 0; p < NUM_RD; p++) begin
                if (ren[p]) begin
                    a = int'(ra[p*ADDR_W +: ADDR_W]);
                    e.stamp = cyc;
                    if (a >= DEPTH) begin
                        e.data   = '0;
                        e.perr   = 1'b0;
                        exp_aerr = 1'b1;
                    end else begin
                        e.data = model[a];
                        e.perr = bad[a];
                    end
                    sb[p].push_back(e);
                end
            end
            if (clr) begin
                clr_left = DEPTH;
                clr_ptr  = 0;
            end
        end
        @(posedge clock);
        #1;
        check("busy", DATA_W'(Busy), DATA_W'(clr_left != 0));
        check("addr_err", DATA_W'(AddrError), DATA_W'(exp_aerr));
        for (int p = 0; p < NUM_RD; p++) begin
            exp_v = (sb[p].size() > 0) && (sb[p][0].stamp == cyc);
            check($sformatf("rvalid%0d", p), DATA_W'(ReadValid[p]), DATA_W'(exp_v));
            if (exp_v) begin
                e = sb[p].pop_front();
                check($sformatf("rdata%0d", p), ReadBus[p*DATA_W +: DATA_W], e.data);
                check($sformatf("perr%0d", p), DATA_W'(ParityError[p]), DATA_W'(e.perr));
                last_data[p] = e.data;
            end else begin
                check($sformatf("rhold%0d", p), ReadBus[p*DATA_W +: DATA_W], last_data[p]);
                check($sformatf("perr_idle%0d", p), DATA_W'(ParityError[p]), '0);
            end
        end
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wr(input int a, input logic [DATA_W-1:0] d, input logic inj);
        drive_cycle(1'b0, 1'b1, ADDR_W'(a), d, inj, '0, '0, 1'b0);
    endtask

    task automatic rd1(input int a);
        logic [NUM_RD*ADDR_W-1:0] ra;
        ra = '0;
        ra[0 +: ADDR_W] = ADDR_W'(a);
        drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, NUM_RD'(1), ra, 1'b0);
    endtask

    task automatic fill_all();
        for (int a = 0; a < DEPTH; a++)
            wr(a, {$urandom, $urandom, $urandom, $urandom | 32'h1}, 1'b0);
    endtask

    task automatic read_all();
        logic [NUM_RD*ADDR_W-1:0] ra;
        for (int a = 0; a < DEPTH; a += NUM_RD) begin
            for (int p = 0; p < NUM_RD; p++) ra[p*ADDR_W +: ADDR_W] = ADDR_W'(a + p);
            drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, '1, ra, 1'b0);
        end
    endtask

    function automatic logic [ADDR_W-1:0] pick_addr();
        case ($urandom_range(0, 9))
            0:       return ADDR_W'(DEPTH);
            1:       return '1;
            default: return ADDR_W'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        logic [NUM_RD*ADDR_W-1:0] ra;
        logic [DATA_W-1:0]        d;
        n_chk = 0; n_pass = 0; cyc = 0; clr_left = 0; clr_ptr = 0;
        reset_n = 1'b0; WE = 1'b0; WriteAddress = '0; WriteBus = '0;
        InjectParity = 1'b0; ReadEnable = '0; ReadAddress = '0; Clear = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            dut.Register[i] = '0;
            model[i] = '0;
            bad[i]   = 1'b0;
        end
        for (int p = 0; p < NUM_RD; p++) last_data[p] = '0;

        // Reset, with requests present that must be ignored
        repeat (3) drive_cycle(1'b1, 1'b1, 16'd2, 128'hDEAD, 1'b0, '1, '0, 1'b1);
        idle_cycle();

        // Write then read-back with one-cycle latency
        wr(5, 128'h1234, 1'b0);
        rd1(5);
        idle_cycle();

        // All ports read an address being written in the same cycle
        wr(7, 128'h55, 1'b0);
        for (int p = 0; p < NUM_RD; p++) ra[p*ADDR_W +: ADDR_W] = 16'd7;
        drive_cycle(1'b0, 1'b1, 16'd7, 128'hAA, 1'b0, '1, ra, 1'b0);
        idle_cycle();

        // Out-of-range read and write
        rd1(DEPTH);
        wr(DEPTH, 128'hFF, 1'b0);
        wr(65535, 128'hFF, 1'b0);
        rd1(0);
        rd1(DEPTH - 1);

        // Parity injection, clean rewrite, and forwarded injected parity
        wr(3, 128'h0F0F, 1'b1);
        rd1(3);
        wr(3, 128'h0F0F, 1'b0);
        rd1(3);
        ra = '0;
        ra[0 +: ADDR_W] = 16'd9;
        drive_cycle(1'b0, 1'b1, 16'd9, 128'h7, 1'b1, NUM_RD'(1), ra, 1'b0);
        wr(9, 128'h7, 1'b0);

        // Random mix of writes and reads over a small window
        for (int k = 0; k < 60; k++) begin
            for (int p = 0; p < NUM_RD; p++) ra[p*ADDR_W +: ADDR_W] = pick_addr();
            d = {$urandom, $urandom, $urandom, $urandom};
            drive_cycle(1'b0, 1'($urandom_range(0, 1)), pick_addr(), d,
                        1'($urandom_range(0, 3) == 0), NUM_RD'($urandom), ra, 1'b0);
        end
        idle_cycle();

        // Full clear sweep with traffic and a repeat Clear while busy
        fill_all();
        drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        for (int k = 0; k < DEPTH; k++) begin
            for (int p = 0; p < NUM_RD; p++) ra[p*ADDR_W +: ADDR_W] = ADDR_W'(k);
            drive_cycle(1'b0, 1'b1, ADDR_W'(k), 128'h1, 1'b0, '1, ra, k == 10);
        end
        read_all();

        // Reset 100 cycles into a sweep leaves the upper words untouched
        fill_all();
        drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        repeat (100) idle_cycle();
        drive_cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        idle_cycle();
        read_all();
        idle_cycle();

        for (int p = 0; p < NUM_RD; p++)
            check($sformatf("sb_empty%0d", p), DATA_W'(sb[p].size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sram_nr1w.md
SRAM_NR1W -- requirements
Module: sram_nr1w

Interface
REQ-001 Parameter DATA_W, default 128, word width in bits.
REQ-002 Parameter ADDR_W, default 16, address width in bits.
REQ-003 Parameter DEPTH, default 1024, number of words; DEPTH SHALL be no greater than 2**ADDR_W.
REQ-004 Parameter NUM_RD, default 2, number of independent read ports, from 1 to 8.
REQ-005 The port list SHALL be as follows; one clock; reset is synchronous and active-low.
- clock  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- WE  input  1  write enable.
- WriteAddress  input  ADDR_W  write address.
- WriteBus  input  DATA_W  write data.
- InjectParity  input  1  when high with WE, store inverted parity (test use only).
- ReadEnable  input  NUM_RD  per-port read request.
- ReadAddress  input  NUM_RD*ADDR_W  port i uses bits [i*ADDR_W +: ADDR_W].
- ReadBus  output  NUM_RD*DATA_W  port i data, registered.
- ReadValid  output  NUM_RD  port i data valid, one cycle after its request.
- ParityError  output  NUM_RD  port i parity mismatch, qualified by ReadValid.
- AddrError  output  1  one-cycle pulse for any out-of-range access.
- Clear  input  1  request to zero the whole array.
- Busy  output  1  high while a clear sweep is in progress.
REQ-006 The storage array SHALL be named Register, DEPTH entries, so benches can load and dump it with $readmemh and $writememh.

Function
REQ-007 FSM states: IDLE and CLEAR; IDLE->CLEAR on Clear high in IDLE; CLEAR->IDLE after the word at DEPTH-1 is written.
REQ-008 In CLEAR, an internal counter SHALL write zero to one word per cycle, from 0 to DEPTH-1 (DEPTH cycles); Busy SHALL be high for exactly those DEPTH cycles.
REQ-009 A Clear request asserted while Busy is high SHALL be ignored.
REQ-010 In CLEAR, external writes SHALL be dropped, ReadValid SHALL stay 0, and ReadBus SHALL hold its last value.
REQ-011 In IDLE, WE high with WriteAddress < DEPTH SHALL write WriteBus to Register[WriteAddress] at the rising edge.
REQ-012 Read latency SHALL be exactly 1 cycle: ReadEnable[i] at edge N gives ReadBus[i] and ReadValid[i] valid after edge N+1.
REQ-013 ReadValid[i] SHALL be 0 in any cycle that follows a cycle with no request on port i; ReadBus[i] SHALL hold its last value when not read.
REQ-014 A read to the same address as a simultaneous write SHALL return the new write data (write-first forwarding), independently on every port.
REQ-015 All read ports MAY address the same word in the same cycle; each SHALL return identical data.
REQ-016 Out-of-range addresses (>= DEPTH):
- a write SHALL be dropped;
- a read SHALL return 0 with ReadValid high;
- AddrError SHALL pulse high for one cycle, aligned with the read data or one cycle after the write.

Reset
REQ-017 While reset_n is low at a rising edge, the following SHALL be cleared: ReadBus to 0, ReadValid to 0, ParityError to 0, AddrError to 0, Busy to 0, FSM to IDLE, clear counter to 0.
REQ-018 Reset SHALL NOT modify Register; a reset during CLEAR SHALL abort the sweep and leave partially cleared contents.
REQ-019 While reset is asserted, writes and reads SHALL be ignored.

Configuration
REQ-020 Macro SRAM_PARITY_EN, when defined:
- each entry SHALL store DATA_W+1 bits, with an even-parity bit computed on write (inverted if InjectParity is high);
- the clear sweep SHALL store parity 0;
- ParityError[i] SHALL assert with ReadValid[i] on a mismatch, with forwarded data carrying the forwarded parity.
REQ-021 Without SRAM_PARITY_EN: entries SHALL be DATA_W bits, ParityError SHALL be tied to 0, and InjectParity SHALL be ignored.

Verification
REQ-022 Write 0x1234 to address 5, then read port 0 at address 5 on the next cycle -> ReadBus[0]=0x1234 and ReadValid[0]=1 exactly one cycle after the request.
REQ-023 In the same cycle, WE to address 7 with data 0xAA and ReadEnable on all ports at address 7 (prior contents 0x55) -> every port returns 0xAA.
REQ-024 Load Register with nonzero data, then pulse Clear -> Busy high for DEPTH (1024) cycles; during Busy, reads give ReadValid=0; afterwards, a read at any address returns 0.
REQ-025 Read at address 1024 with DEPTH=1024 -> ReadBus=0, ReadValid=1, AddrError pulses; write 0xFF to address 1024 -> no entry changes.
REQ-026 With SRAM_PARITY_EN, write address 3 with InjectParity=1, then read it -> ParityError=1; rewrite address 3 with InjectParity=0 and read -> ParityError=0.
REQ-027 Assert reset_n low 100 cycles into a clear sweep -> Busy=0 on the next cycle, entries 0 to 99 are zero, and entries from 100 upward keep their preloaded values.
